// File: rtl/and_chain_scheduler.sv
// and_chain_scheduler
// Two requesters share a single 2-input AND stage. Each accepted operation
// computes E=A&B, F=E&C, G=F&D over three successive cycles. Requesters are
// granted round-robin, and every output comes straight from a register.

module and_chain_scheduler #(
  parameter int WIDTH = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ0,
  input  logic [4*WIDTH-1:0] DIN0,
  input  logic               REQ1,
  input  logic [4*WIDTH-1:0] DIN1,
  output logic               GNT0,
  output logic               GNT1,
  output logic               BUSY,
  output logic [WIDTH-1:0]   E,
  output logic [WIDTH-1:0]   F,
  output logic [WIDTH-1:0]   G,
  output logic               DONE,
  output logic               OWNER
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t               r_state;
  logic [4*WIDTH-1:0]   r_oper;
  logic [WIDTH-1:0]     r_e;
  logic [WIDTH-1:0]     r_f;
  logic [WIDTH-1:0]     r_g;
  logic                 r_gnt0;
  logic                 r_gnt1;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_owner;
  logic                 r_last;

  state_t               w_nextState;
  logic [4*WIDTH-1:0]   w_nextOper;
  logic [WIDTH-1:0]     w_nextE;
  logic [WIDTH-1:0]     w_nextF;
  logic [WIDTH-1:0]     w_nextG;
  logic                 w_nextGnt0;
  logic                 w_nextGnt1;
  logic                 w_nextDone;
  logic                 w_nextOwner;
  logic                 w_nextLast;
  logic                 w_pick;

  logic [WIDTH-1:0]     w_opA;
  logic [WIDTH-1:0]     w_opB;
  logic [WIDTH-1:0]     w_opC;
  logic [WIDTH-1:0]     w_opD;
  logic [WIDTH-1:0]     w_andX;
  logic [WIDTH-1:0]     w_andY;
  logic [WIDTH-1:0]     w_and;

  assign w_opA = r_oper[WIDTH-1:0];
  assign w_opB = r_oper[2*WIDTH-1:WIDTH];
  assign w_opC = r_oper[3*WIDTH-1:2*WIDTH];
  assign w_opD = r_oper[4*WIDTH-1:3*WIDTH];

  // Steer the inputs of the one shared AND stage according to the chain step.
  always_comb begin
    w_andX = '0;
    w_andY = '0;
    case (r_state)
      S1: begin
        w_andX = w_opA;
        w_andY = w_opB;
      end
      S2: begin
        w_andX = r_e;
        w_andY = w_opC;
      end
      S3: begin
        w_andX = r_f;
        w_andY = w_opD;
      end
      default: begin
        w_andX = '0;
        w_andY = '0;
      end
    endcase
  end

  assign w_and = w_andX & w_andY;

  // With both requesting, grant the one that was not granted last time.
  // With only one requesting, grant that one.
  always_comb begin
    if (REQ0 && REQ1) begin
      w_pick = ~r_last;
    end else begin
      w_pick = REQ1;
    end
  end

  // Next-state and next-output logic. Everything holds unless a step updates it.
  always_comb begin
    w_nextState = r_state;
    w_nextOper  = r_oper;
    w_nextE     = r_e;
    w_nextF     = r_f;
    w_nextG     = r_g;
    w_nextGnt0  = 1'b0;
    w_nextGnt1  = 1'b0;
    w_nextDone  = 1'b0;
    w_nextOwner = r_owner;
    w_nextLast  = r_last;
    case (r_state)
      IDLE: begin
        if (REQ0 || REQ1) begin
          w_nextOper  = w_pick ? DIN1 : DIN0;
          w_nextOwner = w_pick;
          w_nextLast  = w_pick;
          w_nextGnt0  = ~w_pick;
          w_nextGnt1  = w_pick;
          w_nextE     = '0;
          w_nextF     = '0;
          w_nextG     = '0;
          w_nextState = S1;
        end
      end
      S1: begin
        w_nextE     = w_and;
        w_nextState = S2;
      end
      S2: begin
        w_nextF     = w_and;
        w_nextState = S3;
      end
      S3: begin
        w_nextG     = w_and;
        w_nextDone  = 1'b1;
        w_nextState = FIN;
      end
      FIN: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State and output registers. Reset aborts any operation in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_oper  <= '0;
      r_e     <= '0;
      r_f     <= '0;
      r_g     <= '0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_oper  <= w_nextOper;
      r_e     <= w_nextE;
      r_f     <= w_nextF;
      r_g     <= w_nextG;
      r_gnt0  <= w_nextGnt0;
      r_gnt1  <= w_nextGnt1;
      r_busy  <= (w_nextState != IDLE);
      r_done  <= w_nextDone;
      r_owner <= w_nextOwner;
      r_last  <= w_nextLast;
    end
  end

  assign GNT0  = r_gnt0;
  assign GNT1  = r_gnt1;
  assign BUSY  = r_busy;
  assign E     = r_e;
  assign F     = r_f;
  assign G     = r_g;
  assign DONE  = r_done;
  assign OWNER = r_owner;

endmodule

// File: doc/and_chain_scheduler.md
AND_CHAIN_SCHEDULER -- requirements
Module: and_chain_scheduler

Interface
REQ-001 The block SHALL have exactly one clock and one reset; the reset SHALL be asynchronous and active-high.
REQ-002 Parameter: WIDTH, default 1, lane width of each AND operand (bitwise AND across WIDTH lanes).
REQ-003 Port: CLK  in  1  rising-edge clock.
REQ-004 Port: RST  in  1  asynchronous active-high reset.
REQ-005 Port: REQ0  in  1  requester 0 operation request (level).
REQ-006 Port: DIN0  in  4*WIDTH  requester 0 operands; A=[WIDTH-1:0], B=[2W-1:W], C=[3W-1:2W], D=[4W-1:3W].
REQ-007 Port: REQ1  in  1  requester 1 operation request (level).
REQ-008 Port: DIN1  in  4*WIDTH  requester 1 operands, same packing as DIN0.
REQ-009 Port: GNT0 / GNT1  out  1 each  one-cycle grant pulse; operands sampled on the same edge.
REQ-010 Port: BUSY  out  1  high in every state except IDLE.
REQ-011 Port: E / F / G  out  WIDTH each  chain partials A&B, E&C, F&D.
REQ-012 Port: DONE  out  1  one-cycle pulse; G final.
REQ-013 Port: OWNER  out  1  index of requester whose result is on E/F/G.

Function
REQ-014 Single shared 2-input AND stage SHALL be time-multiplexed; one AND evaluation per cycle.
REQ-015 FSM states: IDLE, S1, S2, S3, FIN; all outputs registered.
REQ-016 IDLE: on edge with REQ0|REQ1 high -> latch selected DIN into operand register, set OWNER, pulse GNTx, clear E/F/G to 0, go S1; else stay IDLE.
REQ-017 S1 -> S2 on next edge, E <= A&B; S2 -> S3, F <= E&C; S3 -> FIN, G <= F&D, DONE <= 1.
REQ-018 FIN -> IDLE on next edge, DONE <= 0; requests in FIN are not accepted.
REQ-019 Latency: grant edge t -> E valid after t+1, F after t+2, G and DONE after t+3; DONE high exactly one cycle; max throughput one op per 5 cycles.
REQ-020 Arbitration round-robin: pointer LAST (requester last granted); both requesting -> grant the one != LAST; only one requesting -> grant it; LAST updates on each grant.
REQ-021 At most one of GNT0/GNT1 high in any cycle; GNT never high outside the IDLE->S1 edge.
REQ-022 REQ/DIN changes while BUSY SHALL be ignored; result depends only on latched operands.
REQ-023 REQ held high after its grant counts as a new request at next IDLE.
REQ-024 E/F/G/OWNER SHALL hold their values after DONE until the next grant.

Reset
REQ-025 RST high SHALL immediately force IDLE, E=F=G=0, DONE=0, GNT0=GNT1=0, BUSY=0, OWNER=0, LAST=1, operand register 0, regardless of state.
REQ-026 Reset mid-operation SHALL abort with no DONE pulse; first request after release is handled from IDLE normally.

Verification
REQ-027 WIDTH=1, REQ0=1, DIN0=4'b1111 -> GNT0 pulse, E=1 at t+1, F=1 at t+2, G=1 and DONE=1, OWNER=0 at t+3, BUSY low at t+5.
REQ-028 REQ1=1, DIN1=4'b1011 (D=1,C=0,B=1,A=1) -> E=1, F=0, G=0, DONE one cycle, OWNER=1.
REQ-029 After reset, REQ0=REQ1=1 held -> grants GNT0, GNT1, GNT0, GNT1 in successive ops, 5 cycles apart.
REQ-030 RST pulsed while in S2 -> same cycle all outputs 0, BUSY=0, no DONE; then REQ0=1, DIN0=4'b1111 -> G=1 at t+3.
REQ-031 DIN0 changed to 4'b0000 and REQ1 raised during S1 -> result G=1 from latched 4'b1111, REQ1 granted only at first IDLE after FIN.
REQ-032 WIDTH=4, DIN0=16'hF5_3C?-style lanes: D=4'hF, C=4'h5, B=4'h3, A=4'hC -> E=4'h0... use A=4'hF,B=4'hC,C=4'hA,D=4'h7 -> E=4'hC, F=4'h8, G=4'h0.
